// File: rtl/ysyx_22050518_ex_pkg.sv
// Shared types and constants for the execute-stage sequencer.
package ysyx_22050518_ex_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned RD_W_DEF = 5;
  localparam int unsigned OP_W_DEF = 7;

  // Function-field prefixes of ops that keep the ALU busy for several cycles.
  localparam logic [2:0] FN_DIV_PFX = 3'b111;
  localparam logic [2:0] FN_MUL_PFX = 3'b110;

  typedef enum logic [2:0] {
    EX_IDLE,
    EX_ISSUE,
    EX_WAIT,
    EX_HOLD,
    EX_DRAIN
  } ex_state_e;

  function automatic logic is_div_fn(input logic [4:0] fn);
    return fn[4:2] == FN_DIV_PFX;
  endfunction

  function automatic logic is_mul_fn(input logic [4:0] fn);
    return fn[4:2] == FN_MUL_PFX;
  endfunction

  function automatic logic is_multi_fn(input logic [4:0] fn);
    return is_div_fn(fn) | is_mul_fn(fn);
  endfunction

endpackage

// File: rtl/ysyx_22050518_ex_outreg.sv
// EX/MEM output register: valid/ready holding stage with payload capture on done.
module ysyx_22050518_ex_outreg
  import ysyx_22050518_ex_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RD_W = RD_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            done,
  input  logic            ex_ready,
  input  logic [XLEN-1:0] d_result,
  input  logic [RD_W-1:0] d_rd,
  input  logic            d_wen,
  input  logic [XLEN-1:0] d_pc,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_result,
  output logic [RD_W-1:0] ex_rd,
  output logic            ex_wen,
  output logic [XLEN-1:0] ex_pc
);

  // A done on the same edge as a MEM accept replaces the payload and keeps valid set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_result <= '0;
      ex_rd     <= '0;
      ex_wen    <= 1'b0;
      ex_pc     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (done) begin
      ex_valid  <= 1'b1;
      ex_result <= d_result;
      ex_rd     <= d_rd;
      ex_wen    <= d_wen;
      ex_pc     <= d_pc;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22050518_ex_stage.sv
// Execute-stage sequencer: latches one op, drives the fused ALU, buffers against MEM stalls.
// Optional performance counters are built when YSYX_22050518_EX_PERF_EN is defined.
module ysyx_22050518_ex_stage
  import ysyx_22050518_ex_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RD_W = RD_W_DEF,
  parameter int unsigned OP_W = OP_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_in0,
  input  logic [XLEN-1:0] id_in1,
  input  logic [OP_W-1:0] id_alu_op,
  input  logic [RD_W-1:0] id_rd,
  input  logic            id_wen,
  input  logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] alu_in0,
  output logic [XLEN-1:0] alu_in1,
  output logic [OP_W-1:0] alu_op,
  output logic            alu_en,
  input  logic            alu_ready,
  input  logic            alu_valid,
  input  logic [XLEN-1:0] alu_out,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_result,
  output logic [RD_W-1:0] ex_rd,
  output logic            ex_wen,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_stall
);

  ex_state_e       state_q, state_d;
  logic [XLEN-1:0] in0_q, in1_q, pc_q, hold_q;
  logic [OP_W-1:0] op_q;
  logic [RD_W-1:0] rd_q;
  logic            wen_q;

  logic            slot_free;
  logic            done;
  logic            accept;
  logic            hold_load;
  logic [XLEN-1:0] done_result;

  assign slot_free = ~ex_valid | ex_ready;

  always_comb begin
    state_d     = state_q;
    done        = 1'b0;
    done_result = alu_out;
    hold_load   = 1'b0;
    alu_en      = 1'b0;

    case (state_q)
      EX_ISSUE: begin
        alu_en = alu_ready;
        if (alu_ready) begin
          if (alu_valid) begin
            if (slot_free) begin
              done = 1'b1;
            end else begin
              hold_load = 1'b1;
              state_d   = EX_HOLD;
            end
          end else begin
            state_d = EX_WAIT;
          end
        end
      end
      EX_WAIT: begin
        if (alu_valid) begin
          if (slot_free) begin
            done = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_d   = EX_HOLD;
          end
        end
      end
      EX_HOLD: begin
        if (slot_free) begin
          done        = 1'b1;
          done_result = hold_q;
        end
      end
      EX_DRAIN: begin
        if (alu_valid) state_d = EX_IDLE;
      end
      default: ;
    endcase

    // Flush also suppresses the start pulse so a discarded ISSUE never launches a divide.
    if (flush) begin
      done      = 1'b0;
      hold_load = 1'b0;
      alu_en    = 1'b0;
      if (state_q != EX_DRAIN)
        state_d = (state_q == EX_WAIT && !alu_valid) ? EX_DRAIN : EX_IDLE;
    end

    id_ready = ~flush & ((state_q == EX_IDLE) | done);
    accept   = id_valid & id_ready;

    if (accept)    state_d = EX_ISSUE;
    else if (done) state_d = EX_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EX_IDLE;
      in0_q   <= '0;
      in1_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      pc_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in0_q <= id_in0;
        in1_q <= id_in1;
        op_q  <= id_alu_op;
        rd_q  <= id_rd;
        wen_q <= id_wen;
        pc_q  <= id_pc;
      end
      if (hold_load) hold_q <= alu_out;
    end
  end

  assign alu_in0 = in0_q;
  assign alu_in1 = in1_q;
  assign alu_op  = op_q;

  ysyx_22050518_ex_outreg #(
    .XLEN (XLEN),
    .RD_W (RD_W)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .done      (done),
    .ex_ready  (ex_ready),
    .d_result  (done_result),
    .d_rd      (rd_q),
    .d_wen     (wen_q),
    .d_pc      (pc_q),
    .ex_valid  (ex_valid),
    .ex_result (ex_result),
    .ex_rd     (ex_rd),
    .ex_wen    (ex_wen),
    .ex_pc     (ex_pc)
  );

`ifdef YSYX_22050518_EX_PERF_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (done) perf_ops_q <= perf_ops_q + 32'd1;
      if ((ex_valid & ~ex_ready) | (state_q == EX_WAIT) | (state_q == EX_HOLD))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: doc/ysyx_22050518_ex_stage.md
# ysyx_22050518_ex_stage

Execute-stage sequencer between the ID/EX handshake and the EX/MEM pipeline register. It latches one decoded operation, issues it to the fused ALU, and waits for multi-cycle divide/multiply completion. It buffers the result against MEM back-pressure and presents it to MEM on a valid/ready handshake. Flush discards the in-flight operation, including a divide the ALU is still running.

## Interface
- XLEN, 64, datapath width
- RD_W, 5, destination register index width
- OP_W, 7, ALU opcode width; bit 6 = word op, bits 4:0 select the function
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held/in-flight op (synchronous)
- id_valid  in  1  ID offers an op
- id_ready  out  1  stage accepts the op this cycle
- id_in0, id_in1  in  XLEN  operands
- id_alu_op  in  OP_W  ALU opcode
- id_rd  in  RD_W  destination register
- id_wen  in  1  register write enable
- id_pc  in  XLEN  instruction PC
- alu_in0, alu_in1  out  XLEN  registered operands to ALU
- alu_op  out  OP_W  registered opcode to ALU
- alu_en  out  1  start pulse to ALU
- alu_ready  in  1  ALU can accept a start
- alu_valid  in  1  ALU result valid (combinationally 1 for single-cycle ops)
- alu_out  in  XLEN  ALU result
- ex_valid  out  1  result valid to MEM
- ex_ready  in  1  MEM accepts
- ex_result  out  XLEN; ex_rd  out  RD_W; ex_wen  out  1; ex_pc  out  XLEN  payload to MEM
- perf_ops, perf_stall  out  32  performance counters

## Operation
- Slot free: `slot_free = ~ex_valid | ex_ready`.
- Done: the cycle the result is written into the output register.
- States: IDLE, ISSUE, WAIT, HOLD, DRAIN.
- IDLE:
  - id_ready = 1.
  - On id_valid, latch operands and metadata, then go to ISSUE.
- ISSUE:
  - alu_en = alu_ready.
  - If alu_ready and alu_valid: go to done when slot_free; otherwise latch alu_out into the hold register and go to HOLD.
  - If alu_ready and not alu_valid: go to WAIT.
  - If not alu_ready: stay in ISSUE with alu_en low.
- WAIT:
  - alu_en = 0.
  - On alu_valid: go to done when slot_free; otherwise go to HOLD.
- HOLD: when slot_free, move the held result to the output register (done).
- DRAIN:
  - alu_en = 0 and id_ready = 0.
  - On alu_valid, discard the result and go to IDLE.
- id_ready is high in IDLE, and also in any cycle a done occurs. A new op accepted on a done cycle goes directly to ISSUE, giving 1 op/cycle for single-cycle ops.
- Output register:
  - ex_valid is set on done.
  - ex_valid is cleared on ex_ready when there is no simultaneous done.
  - The payload is stable while ex_valid & ~ex_ready.
- Operands and opcode to the ALU are held constant from ISSUE until done or DRAIN exit.
- flush:
  - Clears ex_valid and forces id_ready = 0 that cycle.
  - From WAIT, go to DRAIN, unless alu_valid is high that same cycle, in which case go to IDLE.
  - From all other states, go to IDLE.
  - flush in DRAIN has no further effect.
- alu_valid is ignored outside ISSUE, WAIT and DRAIN.

## Timing
- Reset values:
  - State IDLE.
  - ex_valid = 0, alu_en = 0.
  - All payload and operand registers = 0.
  - id_ready = 1 after reset.
  - perf counters = 0.
- Single-cycle op:
  - ID handshake at edge N, ISSUE in cycle N+1.
  - ex_valid high from edge N+2.
- Multi-cycle op: ex_valid rises on the edge after the alu_valid cycle, provided slot_free.
- alu_en is high for exactly one cycle per op.
- Simultaneous done and MEM accept: ex_valid stays 1 and the payload is replaced.
- Reset mid-divide: the stage returns to IDLE. The ALU is reset by the same reset.

## Configuration
- Macro YSYX_22050518_EX_PERF_EN.
- Defined:
  - perf_ops increments on each done.
  - perf_stall increments each cycle ex_valid & ~ex_ready, or state WAIT/HOLD.
  - Both wrap at 2^32.
- Undefined: both perf ports are tied to 0 and there is no counter logic.

## Structure
- Package ysyx_22050518_ex_pkg:
  - State enum.
  - Multi-cycle op decode constants: divide 5'b111xx, multiply 5'b110xx.
  - XLEN/RD_W/OP_W defaults.
- Sub-module ysyx_22050518_ex_outreg: the output valid/ready register with done/ex_ready update rules.

## Test plan
- ADD (op 7'h00), 5 + 7, ex_ready = 1 → ex_valid at edge N+2 with ex_result = 12, ex_rd/ex_pc matching.
- 4 back-to-back ADDs, ex_ready = 1 → id_ready held high and 4 consecutive ex_valid cycles.
- DIV (op 7'h1C), 100 / 7, model latency 65 cycles → single alu_en pulse, operands stable, ex_result = 14 the cycle after alu_valid.
- DIV completes while ex_ready = 0 → HOLD. Raise ex_ready 3 cycles later → 14 delivered once, no loss.
- flush 10 cycles into a DIV → DRAIN with id_ready = 0. The late alu_valid is discarded, ex_valid never asserts for it, and the next ADD completes normally.
- rst asserted in WAIT → next cycle: IDLE, ex_valid = 0, id_ready = 1, perf counters = 0.
